// File: rtl/iq_ctrl_pkg.sv
// Shared types and constants for the issue-queue sequencing controller.
// The optional IQ_CTRL_PERF_EN macro adds performance counters to iq_ctrl.
package iq_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    FLUSH   = 2'd2,
    RECOVER = 2'd3
  } iq_ctrl_state_e;

  localparam int IQ_DEPTH = 16;
  localparam int IQ_ENQ_W = 4;
  localparam int IQ_ISS_W = 2;

  typedef logic [4:0] iq_cnt_t;

  // Smaller of a requested issue count and the entries actually available.
  function automatic logic [1:0] min_cnt(input logic [1:0] want, input iq_cnt_t avail);
    if ({3'b000, want} <= avail) begin
      min_cnt = want;
    end else begin
      min_cnt = avail[1:0];
    end
  endfunction

endpackage

// File: rtl/iq_ctrl_issue_sel.sv
// In-order issue count: pipe 1 only takes an instruction when pipe 0 also does,
// and the queue never issues more than it holds.
import iq_ctrl_pkg::*;

module iq_issue_sel #(
  parameter int ISS_W = IQ_ISS_W
) (
  input  logic       en,
  input  logic [1:0] pipe_ready,
  input  iq_cnt_t    occupancy,
  output logic [1:0] iss_num
);

  logic [1:0] raw_s;
  logic [1:0] cap_s;

  // Raw pipe capacity, clamped to the issue width, then limited by occupancy.
  always_comb begin
    raw_s   = 2'd0;
    cap_s   = 2'd0;
    iss_num = 2'd0;
    case (pipe_ready)
      2'b01:   raw_s = 2'd1;
      2'b11:   raw_s = 2'd2;
      default: raw_s = 2'd0;
    endcase
    if (raw_s > 2'(ISS_W)) begin
      cap_s = 2'(ISS_W);
    end else begin
      cap_s = raw_s;
    end
    if (en) begin
      iss_num = min_cnt(cap_s, occupancy);
    end else begin
      iss_num = 2'd0;
    end
  end

endmodule

// File: rtl/iq_ctrl.sv
// Issue-queue sequencing controller: occupancy owner, enqueue/issue arbitration,
// flush and drain handling. Define IQ_CTRL_PERF_EN to add stall/issue counters.
import iq_ctrl_pkg::*;

module iq_ctrl #(
  parameter int DEPTH = IQ_DEPTH,
  parameter int ENQ_W = IQ_ENQ_W,
  parameter int ISS_W = IQ_ISS_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  dec_num,
  output logic        dec_stall,
  output logic [2:0]  enq_num,
  input  logic [1:0]  pipe_ready,
  output logic [1:0]  iss_num,
  input  logic        flush,
  input  logic        drain_req,
  output logic        drain_done,
  output logic        iq_clear,
  output logic [4:0]  occupancy,
  output logic [1:0]  state_o
`ifdef IQ_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_issue_cnt
`endif
);

  iq_ctrl_state_e state_r;
  iq_ctrl_state_e state_case_s;
  iq_ctrl_state_e state_nxt_s;
  iq_cnt_t        occ_r;
  iq_cnt_t        occ_nxt_s;
  logic [2:0]     dec_eff_s;
  logic [5:0]     free_s;
  logic [5:0]     occ_sum_s;
  logic           iss_en_s;

  // Out-of-range offers are treated as no offer at all.
  assign dec_eff_s = (dec_num > 3'(ENQ_W)) ? 3'd0 : dec_num;
  assign free_s    = 6'(DEPTH) - {1'b0, occ_r};
  assign occupancy = occ_r;
  assign state_o   = state_r;

  iq_issue_sel #(
    .ISS_W(ISS_W)
  ) u_issue_sel (
    .en         (iss_en_s),
    .pipe_ready (pipe_ready),
    .occupancy  (occ_r),
    .iss_num    (iss_num)
  );

  // Per-state enqueue/issue decisions and the flush-free next state.
  always_comb begin
    state_case_s = state_r;
    enq_num      = 3'd0;
    dec_stall    = 1'b0;
    drain_done   = 1'b0;
    iq_clear     = 1'b0;
    iss_en_s     = 1'b0;
    case (state_r)
      RUN: begin
        iss_en_s = 1'b1;
        // All-or-nothing accept against free space before this cycle's issues.
        if ({3'b000, dec_eff_s} <= free_s) begin
          enq_num   = dec_eff_s;
          dec_stall = 1'b0;
        end else begin
          enq_num   = 3'd0;
          dec_stall = (dec_eff_s != 3'd0);
        end
        if (drain_req) begin
          state_case_s = DRAIN;
        end else begin
          state_case_s = RUN;
        end
      end
      DRAIN: begin
        iss_en_s   = 1'b1;
        dec_stall  = (dec_eff_s != 3'd0);
        drain_done = (occ_r == 5'd0);
        if (drain_req) begin
          state_case_s = DRAIN;
        end else begin
          state_case_s = RUN;
        end
      end
      FLUSH: begin
        iq_clear     = 1'b1;
        dec_stall    = (dec_eff_s != 3'd0);
        state_case_s = RECOVER;
      end
      RECOVER: begin
        dec_stall = (dec_eff_s != 3'd0);
        if (drain_req) begin
          state_case_s = DRAIN;
        end else begin
          state_case_s = RUN;
        end
      end
      default: begin
        state_case_s = RUN;
      end
    endcase
  end

  assign state_nxt_s = flush ? FLUSH : state_case_s;

  // Next occupancy; a flush request discards this cycle's movement.
  always_comb begin
    occ_sum_s = {1'b0, occ_r} + {3'b000, enq_num} - {4'b0000, iss_num};
    occ_nxt_s = occ_r;
    if (state_r == FLUSH) begin
      occ_nxt_s = 5'd0;
    end else if (flush) begin
      occ_nxt_s = occ_r;
    end else if (occ_sum_s > 6'(DEPTH)) begin
      occ_nxt_s = 5'(DEPTH);
    end else begin
      occ_nxt_s = occ_sum_s[4:0];
    end
  end

  // State and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= RUN;
      occ_r   <= 5'd0;
    end else begin
      state_r <= state_nxt_s;
      occ_r   <= occ_nxt_s;
    end
  end

`ifdef IQ_CTRL_PERF_EN
  // Free-running performance counters; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= 32'd0;
      perf_issue_cnt <= 32'd0;
    end else begin
      perf_stall_cnt <= perf_stall_cnt + {31'd0, dec_stall};
      perf_issue_cnt <= perf_issue_cnt + {30'd0, iss_num};
    end
  end
`endif

endmodule

// File: tb/tb_iq_ctrl.sv
// Directed plus randomized bench for iq_ctrl against a behavioural queue model.
module tb_iq_ctrl;

  localparam int S_RUN     = 0;
  localparam int S_DRAIN   = 1;
  localparam int S_FLUSH   = 2;
  localparam int S_RECOVER = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  dec_num;
  logic        dec_stall;
  logic [2:0]  enq_num;
  logic [1:0]  pipe_ready;
  logic [1:0]  iss_num;
  logic        flush;
  logic        drain_req;
  logic        drain_done;
  logic        iq_clear;
  logic [4:0]  occupancy;
  logic [1:0]  state_o;
`ifdef IQ_CTRL_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_issue_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  int m_state;
  int m_occ;
  int e_enq, e_iss, e_stall, e_done, e_clear;
  logic [31:0] m_pstall;
  logic [31:0] m_piss;

  iq_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .dec_num    (dec_num),
    .dec_stall  (dec_stall),
    .enq_num    (enq_num),
    .pipe_ready (pipe_ready),
    .iss_num    (iss_num),
    .flush      (flush),
    .drain_req  (drain_req),
    .drain_done (drain_done),
    .iq_clear   (iq_clear),
    .occupancy  (occupancy),
    .state_o    (state_o)
`ifdef IQ_CTRL_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_issue_cnt (perf_issue_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected combinational outputs from the queue's current mode and fill level.
  task automatic model_out();
    int dec;
    int cap;
    dec = (dec_num <= 3'd4) ? int'(dec_num) : 0;
    cap = pipe_ready[0] ? (pipe_ready[1] ? 2 : 1) : 0;
    e_iss   = (m_state == S_RUN || m_state == S_DRAIN) ? ((cap < m_occ) ? cap : m_occ) : 0;
    e_enq   = (m_state == S_RUN && dec <= 16 - m_occ) ? dec : 0;
    e_stall = (dec != 0 && e_enq == 0) ? 1 : 0;
    e_done  = (m_state == S_DRAIN && m_occ == 0) ? 1 : 0;
    e_clear = (m_state == S_FLUSH) ? 1 : 0;
  endtask

  task automatic step(input int d, input int pr, input bit fl, input bit dr, input bit r,
                      input string tag);
    dec_num    = 3'(d);
    pipe_ready = 2'(pr);
    flush      = fl;
    drain_req  = dr;
    rst        = r;
    #1;
    model_out();
    chk({tag, ":enq_num"},    32'(enq_num),    32'(e_enq));
    chk({tag, ":iss_num"},    32'(iss_num),    32'(e_iss));
    chk({tag, ":dec_stall"},  32'(dec_stall),  32'(e_stall));
    chk({tag, ":drain_done"}, 32'(drain_done), 32'(e_done));
    chk({tag, ":iq_clear"},   32'(iq_clear),   32'(e_clear));
    chk({tag, ":state"},      32'(state_o),    32'(m_state));
    if (m_state != S_FLUSH) begin
      chk({tag, ":occupancy"}, 32'(occupancy), 32'(m_occ));
    end
    @(posedge clk);
    if (r) begin
      m_pstall = 32'd0;
      m_piss   = 32'd0;
      m_state  = S_RUN;
      m_occ    = 0;
    end else begin
      m_pstall = m_pstall + 32'(e_stall);
      m_piss   = m_piss + 32'(e_iss);
      if (m_state == S_FLUSH) m_occ = 0;
      else if (!fl) m_occ = m_occ + e_enq - e_iss;
      if (fl) m_state = S_FLUSH;
      else if (m_state == S_FLUSH) m_state = S_RECOVER;
      else m_state = dr ? S_DRAIN : S_RUN;
    end
    @(negedge clk);
  endtask

  initial begin
    bit drv;
    rst = 1'b1; dec_num = 3'd0; pipe_ready = 2'b00; flush = 1'b0; drain_req = 1'b0;
    drv = 1'b0;
    m_state = S_RUN; m_occ = 0; m_pstall = 32'd0; m_piss = 32'd0;
    @(negedge clk);
    @(negedge clk);
    step(0, 0, 0, 0, 1, "reset");

    // Fill to full, then a refused offer.
    for (int i = 0; i < 4; i++) step(4, 0, 0, 0, 0, "fill");
    chk("plan_full_occ", 32'(occupancy), 32'd16);
    step(4, 0, 0, 0, 0, "full_offer");
    step(0, 1, 0, 0, 0, "to15");
    step(2, 3, 0, 0, 0, "occ15_dual");
    chk("plan_occ13", 32'(occupancy), 32'd13);
    for (int i = 0; i < 6; i++) step(0, 3, 0, 0, 0, "empty_down");
    step(0, 2, 0, 0, 0, "pipe1_only");
    step(0, 3, 0, 0, 0, "occ1_dual");
    step(0, 3, 0, 0, 0, "empty_issue");

    // Flush from occupancy 10.
    step(4, 0, 0, 0, 0, "f10a");
    step(4, 0, 0, 0, 0, "f10b");
    step(2, 0, 0, 0, 0, "f10c");
    step(3, 3, 1, 0, 0, "flush_req");
    step(3, 3, 0, 0, 0, "flush_state");
    step(3, 3, 0, 0, 0, "recover");
    chk("plan_flush_occ0", 32'(occupancy), 32'd0);
    step(0, 0, 0, 0, 0, "run_again");

    // Drain from occupancy 3.
    step(3, 0, 0, 0, 0, "pre_drain");
    step(0, 0, 0, 1, 0, "drain_req");
    for (int i = 0; i < 3; i++) step(2, 1, 0, 1, 0, "draining");
    step(0, 1, 0, 1, 0, "drained");
    step(0, 0, 0, 0, 0, "drain_exit");
    step(0, 0, 0, 0, 0, "after_drain");

    // Flush and drain together.
    step(1, 0, 1, 1, 0, "flush_drain");
    step(1, 0, 0, 1, 0, "fd_flush");
    step(1, 0, 0, 1, 0, "fd_recover");
    step(1, 0, 0, 1, 0, "fd_drain");
    step(7, 3, 0, 0, 0, "illegal_dec");

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) drv = ~drv;
      step(int'($urandom_range(0, 7)),
           ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 3)),
           ($urandom_range(0, 24) == 0), drv,
           ($urandom_range(0, 149) == 0), "rand");
    end

`ifdef IQ_CTRL_PERF_EN
    chk("perf_stall", perf_stall_cnt, m_pstall);
    chk("perf_issue", perf_issue_cnt, m_piss);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
